// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: shared encodings, FSM state type and channel-id width helper
package sram_like_arbiter_pkg;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
    function automatic int ch_id_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sram_like_arbiter_order_fifo.sv
// arb_order_fifo: in-order channel-id queue; same-cycle push and pop are legal
module arb_order_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == ($clog2(DEPTH)+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + ($clog2(DEPTH)+1)'(do_push) - ($clog2(DEPTH)+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges NUM_CH sram-like masters onto one slave, routing in-order responses back
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR_MODE         = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CH-1:0]             m_req,
    input  logic [NUM_CH-1:0]             m_wr,
    input  logic [2*NUM_CH-1:0]           m_size,
    input  logic [DATA_W/8*NUM_CH-1:0]    m_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]      m_addr,
    input  logic [DATA_W*NUM_CH-1:0]      m_wdata,
    output logic [NUM_CH-1:0]             m_addr_ok,
    output logic [NUM_CH-1:0]             m_data_ok,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          s_req,
    output logic                          s_wr,
    output logic [1:0]                    s_size,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic                          s_addr_ok,
    input  logic                          s_data_ok,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                          proto_err
);
    localparam int ID_W = ch_id_w(NUM_CH);
    localparam int SB_W = DATA_W/8;
    arb_state_e state, state_n;
    logic [ID_W-1:0] lock_id, lock_n, ptr, winner, sel, head;
    logic full, empty, accept, pop;
    // Scan from the base upward so the first requester at or after it wins.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_CH-1:0] req, input logic [ID_W-1:0] base);
        logic [ID_W-1:0] w = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            logic [ID_W-1:0] k = ID_W'(RR_MODE != 0 ? (int'(base) + i) % NUM_CH : i);
            if (req[k]) w = k;
        end
        return w;
    endfunction
    assign winner = pick(m_req, ptr);
    always_comb begin
        state_n = state;
        lock_n  = lock_id;
        sel     = winner;
        s_req   = 1'b0;
        if (state == LOCKED) begin
            sel   = lock_id;
            s_req = ~full;
            if (s_addr_ok && !full) state_n = IDLE;
        end else if (|m_req && !full) begin
            s_req = 1'b1;
            if (!s_addr_ok) begin
                state_n = LOCKED;
                lock_n  = winner;
            end
        end
    end
    assign accept    = s_req & s_addr_ok;
    assign pop       = s_data_ok & ~empty;
    assign m_addr_ok = accept ? NUM_CH'(1) << sel : '0;
    assign m_data_ok = pop ? NUM_CH'(1) << head : '0;
    assign m_rdata   = pop ? s_rdata : '0;
    assign s_wr      = s_req & m_wr[sel];
    assign s_size    = s_req ? m_size[int'(sel)*2 +: 2] : '0;
    assign s_wstrb   = s_req ? m_wstrb[int'(sel)*SB_W +: SB_W] : '0;
    assign s_addr    = s_req ? m_addr[int'(sel)*ADDR_W +: ADDR_W] : '0;
    assign s_wdata   = s_req ? m_wdata[int'(sel)*DATA_W +: DATA_W] : '0;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            lock_id   <= '0;
            ptr       <= '0;
            proto_err <= 1'b0;
        end else begin
            state   <= state_n;
            lock_id <= lock_n;
            if (accept) ptr <= ID_W'((int'(sel) + 1) % NUM_CH);
            if (s_data_ok && empty) proto_err <= 1'b1;
        end
    end
    arb_order_fifo #(.W(ID_W), .DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk(clk), .resetn(resetn), .push(accept), .pop(pop), .din(sel),
        .dout(head), .full(full), .empty(empty), .count(outstanding)
    );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed checks of a fixed-priority and a round-robin arbiter instance
module tb_sram_like_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    logic [1:0]  m_req = '0, m_addr_ok, m_data_ok;
    logic [1:0]  m_wr = 2'b10;
    logic [3:0]  m_size = 4'b1000;
    logic [7:0]  m_wstrb = 8'hF1;
    logic [63:0] m_addr = {32'h0000_2000, 32'h0000_1000};
    logic [63:0] m_wdata = {32'h0000_CAFE, 32'h0000_BEEF};
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata = '0;
    logic        s_req, s_wr, s_addr_ok = 1'b0, s_data_ok = 1'b0, proto_err;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [2:0]  outstanding;
    logic [1:0]  r_req = '0, r_addr_ok, r_data_ok;
    logic [31:0] r_rdata, r_s_addr, r_s_wdata;
    logic        r_s_req, r_s_wr, r_aok = 1'b0, r_proto_err;
    logic [1:0]  r_s_size;
    logic [3:0]  r_s_wstrb;
    logic [2:0]  r_outstanding;
    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .RR_MODE(0)) dut_fix (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );
    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .RR_MODE(1)) dut_rr (
        .clk(clk), .resetn(resetn), .m_req(r_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(r_addr_ok), .m_data_ok(r_data_ok), .m_rdata(r_rdata),
        .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_wstrb(r_s_wstrb), .s_addr(r_s_addr),
        .s_wdata(r_s_wdata), .s_addr_ok(r_aok), .s_data_ok(1'b0), .s_rdata(32'h0),
        .outstanding(r_outstanding), .proto_err(r_proto_err)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] drain_exp [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_aok", 32'(m_addr_ok), 0);
        chk("rst_sreq", 32'(s_req), 0);
        chk("rst_perr", 32'(proto_err), 0);
        resetn = 1'b1;
        // round-robin: both request continuously, slave always accepts
        @(negedge clk); r_req = 2'b11; r_aok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rr_grant%0d", i), 32'(r_addr_ok), 32'(rr_exp[i]));
            @(negedge clk);
        end
        #1 chk("rr_full_sreq", 32'(r_s_req), 0);
        chk("rr_full_out", 32'(r_outstanding), 4);
        r_req = 2'b00; r_aok = 1'b0;
        // fixed priority: simultaneous requests
        @(negedge clk); m_req = 2'b11; s_addr_ok = 1'b1;
        #1 chk("t1_aok0", 32'(m_addr_ok), 32'b01);
        chk("t1_addr0", s_addr, 32'h1000);
        @(negedge clk); m_req = 2'b10;
        #1 chk("t1_aok1", 32'(m_addr_ok), 32'b10);
        chk("t1_out1", 32'(outstanding), 1);
        @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h11;
        #1 chk("t1_dok0", 32'(m_data_ok), 32'b01);
        chk("t1_rdata0", m_rdata, 32'h11);
        chk("t1_out2", 32'(outstanding), 2);
        @(negedge clk); s_rdata = 32'h22;
        #1 chk("t1_dok1", 32'(m_data_ok), 32'b10);
        chk("t1_rdata1", m_rdata, 32'h22);
        @(negedge clk); s_data_ok = 1'b0;
        #1 chk("t1_out0", 32'(outstanding), 0);
        // lock on ch1 while slave stalls, ch0 arrives later
        @(negedge clk); m_req = 2'b10;
        #1 chk("t3_sreq", 32'(s_req), 1);
        chk("t3_addr", s_addr, 32'h2000);
        chk("t3_wr", 32'(s_wr), 1);
        chk("t3_wdata", s_wdata, 32'hCAFE);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); m_req = 2'b11;
            #1 chk($sformatf("t3_hold%0d", i), s_addr, 32'h2000);
            chk($sformatf("t3_noaok%0d", i), 32'(m_addr_ok), 0);
        end
        @(negedge clk); s_addr_ok = 1'b1;
        #1 chk("t3_aok1", 32'(m_addr_ok), 32'b10);
        chk("t3_size", 32'(s_size), 2);
        @(negedge clk); m_req = 2'b01;
        #1 chk("t3_aok0", 32'(m_addr_ok), 32'b01);
        chk("t3_addr0", s_addr, 32'h1000);
        @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0;
        #1 chk("t3_out2", 32'(outstanding), 2);
        // accept and response in the same cycle; head is ch1
        @(negedge clk); m_req = 2'b01; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hDEADBEEF;
        #1 chk("t5_dok", 32'(m_data_ok), 32'b10);
        chk("t5_rdata", m_rdata, 32'hDEADBEEF);
        chk("t5_aok", 32'(m_addr_ok), 32'b01);
        @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        #1 chk("t5_out", 32'(outstanding), 2);
        // fill to full, pop once without bypass, then resume
        @(negedge clk); m_req = 2'b10; s_addr_ok = 1'b1;
        #1 chk("t4_aok_a", 32'(m_addr_ok), 32'b10);
        @(negedge clk);
        #1 chk("t4_aok_b", 32'(m_addr_ok), 32'b10);
        @(negedge clk);
        #1 chk("t4_full_out", 32'(outstanding), 4);
        chk("t4_full_sreq", 32'(s_req), 0);
        chk("t4_full_aok", 32'(m_addr_ok), 0);
        @(negedge clk); s_data_ok = 1'b1;
        #1 chk("t4_nobypass", 32'(s_req), 0);
        chk("t4_pop", 32'(m_data_ok), 32'b01);
        @(negedge clk); s_data_ok = 1'b0;
        #1 chk("t4_resume", 32'(m_addr_ok), 32'b10);
        chk("t4_out3", 32'(outstanding), 3);
        @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("drain%0d", i), 32'(m_data_ok), 32'(drain_exp[i]));
            @(negedge clk);
        end
        // response with nothing in flight
        #1 chk("t6_nodok", 32'(m_data_ok), 0);
        chk("t6_perr0", 32'(proto_err), 0);
        @(negedge clk); s_data_ok = 1'b0;
        #1 chk("t6_perr1", 32'(proto_err), 1);
        @(negedge clk);
        #1 chk("t6_sticky", 32'(proto_err), 1);
        // async reset mid-flight, then a late response
        @(negedge clk); m_req = 2'b01; s_addr_ok = 1'b1;
        @(negedge clk); m_req = 2'b00; s_addr_ok = 1'b0;
        #1 chk("t6_inflight", 32'(outstanding), 1);
        resetn = 1'b0;
        #1 chk("t6_rst_out", 32'(outstanding), 0);
        chk("t6_rst_perr", 32'(proto_err), 0);
        chk("t6_rst_rr", 32'(r_outstanding), 0);
        @(negedge clk); resetn = 1'b1;
        @(negedge clk); s_data_ok = 1'b1;
        #1 chk("t6_late_dok", 32'(m_data_ok), 0);
        @(negedge clk); s_data_ok = 1'b0;
        #1 chk("t6_late_perr", 32'(proto_err), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
